// File: rtl/audio_sample_fifo_pkg.sv
// audio_pkg: shared definitions for the audio sample FIFO.
//   - default per-channel sample width
//   - Avalon register word addresses
//   - bit positions inside STATUS, CTRL and CMD
//   - layout of one stored stereo sample pair
package audio_pkg;

    localparam int DATA_W_DEF = 24;

    // Register word addresses (3-bit Avalon address)
    localparam logic [2:0] REG_LEFT   = 3'd0;
    localparam logic [2:0] REG_RIGHT  = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_DROPS  = 3'd4;
    localparam logic [2:0] REG_CMD    = 3'd5;

    // STATUS bits
    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_OVERFLOW  = 2;
    localparam int STATUS_COUNT_LSB = 8;

    // CTRL bits
    localparam int CTRL_IRQ_EN      = 0;
    localparam int CTRL_THRESH_LSB  = 8;

    // CMD bits (self-clearing strobes)
    localparam int CMD_FLUSH        = 0;
    localparam int CMD_CLEAR_OVF    = 1;

    // One stored entry: left channel in the upper half, right in the lower
    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: groups the I2S sample push port and the Avalon-MM
// slave port of the audio sample FIFO.
//   sample_valid/left/right : push side from the I2S decoder
//   chipselect/read/write/address/writedata : Avalon requests from the HPS
//   readdata : registered read data, irq : level interrupt
// master = I2S decoder + HPS side, slave = the FIFO.
interface audio_sample_fifo_if
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [2:0]        address;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    modport master (
        output sample_valid, sample_left, sample_right,
        output chipselect, read, write, address, writedata,
        input  readdata, irq
    );

    modport slave (
        input  sample_valid, sample_left, sample_right,
        input  chipselect, read, write, address, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/audio_sample_fifo_ram.sv
// audio_sample_ram: DEPTH x WIDTH sample storage.
//   clk   : clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   raddr : read address, rdata is combinational so the register read path
//           from head entry to readdata stays a single registered cycle
// Contents are not reset.
module audio_sample_ram #(
    parameter int WIDTH  = 48,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: buffers stereo PCM sample pairs from the I2S receiver
// and hands them to the HPS over an Avalon-MM slave with pop-on-read.
//   clk   : 50 MHz system clock
//   reset : asynchronous active-high reset
//   bus   : audio_sample_fifo_if.slave (sample push port, Avalon slave, irq)
// Reading RIGHT pops the head pair; LEFT is a non-destructive peek.
// Overflow is sticky and counted in a saturating 16-bit drop counter.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    audio_sample_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic [15:0]       drops_reg;
    logic              irq_en_reg;
    logic [7:0]        threshold_reg;
    logic [31:0]       readdata_reg;
    logic              irq_reg;
    logic [31:0]       readdata_next;

    logic [2*DATA_W-1:0] head_pair;
    logic [DATA_W-1:0]   head_left;
    logic [DATA_W-1:0]   head_right;
    logic [7:0]          count_ext;

    logic rd_sel, wr_sel, empty, full;
    logic pop, push_ok, overflow_event, flush, clear_ovf;

    // Bits of the write data bus that no register uses
    logic unused_wdata;
    assign unused_wdata = ^{bus.writedata[31:16], bus.writedata[7:2]};

    assign rd_sel    = bus.chipselect & bus.read;
    assign wr_sel    = bus.chipselect & bus.write;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_C);
    assign count_ext = 8'(count_reg);

    assign flush     = wr_sel && (bus.address == REG_CMD) && bus.writedata[CMD_FLUSH];
    assign clear_ovf = wr_sel && (bus.address == REG_CMD) && bus.writedata[CMD_CLEAR_OVF];
    assign pop       = rd_sel && (bus.address == REG_RIGHT) && !empty;

    // A pop on the same edge frees the slot, so a push into a full FIFO is
    // still accepted. A flush discards the push without counting a drop.
    assign push_ok        = bus.sample_valid && (!full || pop) && !flush;
    assign overflow_event = bus.sample_valid && full && !pop && !flush;

    audio_sample_ram #(
        .WIDTH  (2 * DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_reg),
        .wdata ({bus.sample_left, bus.sample_right}),
        .raddr (rd_ptr_reg),
        .rdata (head_pair)
    );

    assign head_left  = head_pair[2*DATA_W-1:DATA_W];
    assign head_right = head_pair[DATA_W-1:0];

    // Read mux sees pre-edge state; a same-cycle pop/push only moves
    // pointers and count at the edge that captures this value.
    always_comb begin
        readdata_next = '0;
        case (bus.address)
            REG_LEFT:   readdata_next = empty ? 32'h0 : 32'(head_left);
            REG_RIGHT:  readdata_next = empty ? 32'h0 : 32'(head_right);
            REG_STATUS: begin
                readdata_next[STATUS_EMPTY]    = empty;
                readdata_next[STATUS_FULL]     = full;
                readdata_next[STATUS_OVERFLOW] = overflow_reg;
                readdata_next[STATUS_COUNT_LSB +: 8] = count_ext;
            end
            REG_CTRL: begin
                readdata_next[CTRL_IRQ_EN]         = irq_en_reg;
                readdata_next[CTRL_THRESH_LSB +: 8] = threshold_reg;
            end
            REG_DROPS:  readdata_next = {16'h0, drops_reg};
            default:    readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            drops_reg     <= '0;
            irq_en_reg    <= 1'b0;
            threshold_reg <= '0;
            readdata_reg  <= '0;
            irq_reg       <= 1'b0;
        end else begin
            if (rd_sel) begin
                readdata_reg <= readdata_next;
            end

            irq_reg <= irq_en_reg && (count_ext >= threshold_reg) && (threshold_reg != 8'h0);

            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
                else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
            end

            // An overflow on the clearing edge wins and restarts the count at 1
            if (overflow_event) begin
                overflow_reg <= 1'b1;
                if (clear_ovf)                drops_reg <= 16'h1;
                else if (drops_reg != 16'hFFFF) drops_reg <= drops_reg + 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
                drops_reg    <= '0;
            end

            if (wr_sel && bus.address == REG_CTRL) begin
                irq_en_reg    <= bus.writedata[CTRL_IRQ_EN];
                threshold_reg <= bus.writedata[CTRL_THRESH_LSB +: 8];
            end
        end
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = irq_reg;
endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;
    import audio_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    audio_sample_fifo_if #(.DATA_W(24)) bus_if ();

    audio_sample_fifo #(.DATA_W(24), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        d = bus_if.readdata;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = wd;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_left  = l;
        bus_if.sample_right = r;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
    endtask

    // Push coincident with a RIGHT read
    task automatic push_and_pop(input logic [23:0] l, input logic [23:0] r, output logic [31:0] d);
        @(negedge clk);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_left  = l;
        bus_if.sample_right = r;
        bus_if.chipselect   = 1'b1;
        bus_if.read         = 1'b1;
        bus_if.address      = REG_RIGHT;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.chipselect   = 1'b0;
        bus_if.read         = 1'b0;
        d = bus_if.readdata;
    endtask

    // Push coincident with a CMD write
    task automatic push_and_cmd(input logic [23:0] l, input logic [23:0] r, input logic [31:0] wd);
        @(negedge clk);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_left  = l;
        bus_if.sample_right = r;
        bus_if.chipselect   = 1'b1;
        bus_if.write        = 1'b1;
        bus_if.address      = REG_CMD;
        bus_if.writedata    = wd;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.chipselect   = 1'b0;
        bus_if.write        = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [23:0] el, er;

        reset               = 1'b1;
        bus_if.sample_valid = 1'b0;
        bus_if.sample_left  = '0;
        bus_if.sample_right = '0;
        bus_if.chipselect   = 1'b0;
        bus_if.read         = 1'b0;
        bus_if.write        = 1'b0;
        bus_if.address      = '0;
        bus_if.writedata    = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_readdata", bus_if.readdata, 32'h0);
        check_eq("reset_irq", {31'h0, bus_if.irq}, 32'h0);
        reset = 1'b0;

        // Empty FIFO behaviour
        bus_read(REG_STATUS, d); check_eq("status_after_reset", d, 32'h0000_0001);
        bus_read(REG_RIGHT, d);  check_eq("right_when_empty", d, 32'h0);
        bus_read(REG_STATUS, d); check_eq("status_after_empty_pop", d, 32'h0000_0001);

        // Single pair round trip
        push(24'h123456, 24'hABCDEF);
        bus_read(REG_LEFT, d);   check_eq("single_left", d, 32'h0012_3456);
        bus_read(REG_RIGHT, d);  check_eq("single_right", d, 32'h00AB_CDEF);
        bus_read(REG_STATUS, d); check_eq("single_status_after", d, 32'h0000_0001);

        // Overfill by two
        for (int i = 0; i < 66; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        bus_read(REG_STATUS, d); check_eq("overfill_status", d, 32'h0000_4006);
        bus_read(REG_DROPS, d);  check_eq("overfill_drops", d, 32'h0000_0002);
        for (int i = 0; i < 64; i++) begin
            bus_read(REG_LEFT, d);  check_eq($sformatf("drain_left_%0d", i), d, 32'h0010_0000 + 32'(i));
            bus_read(REG_RIGHT, d); check_eq($sformatf("drain_right_%0d", i), d, 32'h0020_0000 + 32'(i));
        end
        bus_read(REG_STATUS, d); check_eq("drained_status_ovf", d, 32'h0000_0005);
        bus_write(REG_CMD, 32'h2);
        bus_read(REG_STATUS, d); check_eq("clear_ovf_status", d, 32'h0000_0001);
        bus_read(REG_DROPS, d);  check_eq("clear_ovf_drops", d, 32'h0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 64; i++) push(24'h300000 + 24'(i), 24'h400000 + 24'(i));
        push_and_pop(24'hAAAAAA, 24'hBBBBBB, d);
        check_eq("full_pushpop_right", d, 32'h0040_0000);
        bus_read(REG_STATUS, d); check_eq("full_pushpop_status", d, 32'h0000_4002);
        for (int i = 0; i < 64; i++) begin
            el = (i == 63) ? 24'hAAAAAA : 24'h300000 + 24'(i + 1);
            er = (i == 63) ? 24'hBBBBBB : 24'h400000 + 24'(i + 1);
            bus_read(REG_LEFT, d);  check_eq($sformatf("pp_left_%0d", i), d, {8'h0, el});
            bus_read(REG_RIGHT, d); check_eq($sformatf("pp_right_%0d", i), d, {8'h0, er});
        end
        bus_read(REG_DROPS, d);  check_eq("pushpop_no_drop", d, 32'h0);

        // Threshold interrupt
        bus_write(REG_CTRL, 32'hFFFF_0401);
        bus_read(REG_CTRL, d);   check_eq("ctrl_readback", d, 32'h0000_0401);
        for (int i = 0; i < 3; i++) push(24'h000010 + 24'(i), 24'h000020 + 24'(i));
        @(negedge clk);
        check_eq("irq_below_thresh", {31'h0, bus_if.irq}, 32'h0);
        push(24'h000013, 24'h000023);
        check_eq("irq_same_cycle", {31'h0, bus_if.irq}, 32'h0);
        @(negedge clk);
        check_eq("irq_asserted", {31'h0, bus_if.irq}, 32'h1);
        bus_read(REG_RIGHT, d);  check_eq("irq_pop_data", d, 32'h0000_0020);
        check_eq("irq_held_at_pop", {31'h0, bus_if.irq}, 32'h1);
        @(negedge clk);
        check_eq("irq_deasserted", {31'h0, bus_if.irq}, 32'h0);
        for (int i = 0; i < 3; i++) bus_read(REG_RIGHT, d);
        bus_write(REG_CTRL, 32'h0);

        // Flush with coincident push
        for (int i = 0; i < 5; i++) push(24'h500000 + 24'(i), 24'h600000 + 24'(i));
        bus_read(REG_STATUS, d); check_eq("pre_flush_status", d, 32'h0000_0500);
        push_and_cmd(24'hDEADBE, 24'hEFEFEF, 32'h1);
        bus_read(REG_STATUS, d); check_eq("flush_status", d, 32'h0000_0001);
        bus_read(REG_DROPS, d);  check_eq("flush_drops", d, 32'h0);
        push(24'h777777, 24'h888888);
        bus_read(REG_LEFT, d);   check_eq("post_flush_left", d, 32'h0077_7777);

        // Asynchronous reset mid-fill
        push(24'h111111, 24'h222222);
        bus_read(REG_STATUS, d); check_eq("pre_reset_status", d, 32'h0000_0200);
        bus_write(REG_CTRL, 32'h0000_0101);
        @(negedge clk);
        check_eq("pre_reset_irq", {31'h0, bus_if.irq}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_readdata", bus_if.readdata, 32'h0);
        check_eq("async_reset_irq", {31'h0, bus_if.irq}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(REG_STATUS, d); check_eq("post_reset_status", d, 32'h0000_0001);
        bus_read(REG_CTRL, d);   check_eq("post_reset_ctrl", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
